camera_config_sequencer: RTL and testbench
==========================================

// Module: camera_config_sequencer
// PURPOSE
//  Sequences writes of the camera geometry/exposure registers (start row/col, sizes, modes, exposure)
//  to the image sensor through a register-write master (I2C) using a req/ack handshake.
//  Sits between the Avalon camera register bank and the I2C master; reconfigures automatically
//  on power-up, after camera soft reset, on any register change, or on explicit request.
// PARAMETERS
//  DEV_ADDR       8'hBA    sensor bus device (write) address driven on i2c_dev
//  SETTLE_CYCLES  50000    clk cycles waited after reset/soft-reset release before first pass
//  ACK_TIMEOUT    65535    clk cycles WAIT tolerates without i2c_ack before counting a failed attempt
//  RETRY_MAX      3        retries per register after a failed attempt (total attempts = RETRY_MAX+1)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  cam_soft_reset_n  in   1   camera soft reset from register bank; low aborts and holds sequencer
//  start_row         in  16   sensor reg 0x01 value
//  start_column      in  16   sensor reg 0x02 value
//  row_size          in  16   sensor reg 0x03 value
//  column_size       in  16   sensor reg 0x04 value
//  row_mode          in  16   sensor reg 0x22 value
//  column_mode       in  16   sensor reg 0x23 value
//  exposure          in  16   sensor reg 0x09 value
//  cfg_start         in   1   one-cycle request for a full pass (also clears cfg_error)
//  i2c_req           out  1   write request; held high until i2c_ack
//  i2c_dev           out  8   device address (= DEV_ADDR)
//  i2c_reg           out  8   sensor register address
//  i2c_data          out 16   sensor register data
//  i2c_ack           in   1   one-cycle completion strobe from master
//  i2c_err           in   1   valid with i2c_ack; 1 = NACK / bus error
//  cfg_busy          out  1   high in every state except IDLE
//  cfg_done          out  1   one-cycle pulse after a pass completes with all 7 writes acknowledged OK
//  cfg_error         out  1   sticky: a register exhausted its retries
// BEHAVIOUR
//  States: HOLD, SETTLE, IDLE, LOAD, ISSUE, WAIT, NEXT, DONE.
//  reset: state=SETTLE, settle counter=SETTLE_CYCLES, idx=0, retry=0, pending=0; outputs 0 except i2c_dev=DEV_ADDR.
//  cam_soft_reset_n low (any state, checked before all other transitions): -> HOLD, i2c_req=0 next cycle;
//   HOLD -> SETTLE when cam_soft_reset_n high. An in-flight write is abandoned; late ack is ignored.
//  SETTLE: counts down to 0, then -> LOAD (one mandatory full pass).
//  IDLE: -> LOAD if cfg_start, pending, or any input value != its shadow copy.
//  LOAD (1 cycle): copy all 7 inputs into shadow regs; idx=0, retry=0; pending=0. Writes use shadows only.
//  ISSUE: drive i2c_reg/i2c_data from table[idx], i2c_req=1, timeout counter cleared -> WAIT.
//   Order idx0..6: 0x01,0x02,0x03,0x04,0x22,0x23,0x09. i2c_reg/i2c_data stable while i2c_req=1.
//  WAIT: i2c_ack & !i2c_err -> i2c_req=0, -> NEXT. i2c_ack & i2c_err, or timeout counter reaching
//   ACK_TIMEOUT -> failed attempt: i2c_req=0; retry<RETRY_MAX: retry++, -> ISSUE (min 1 cycle req low);
//   else cfg_error=1, -> IDLE (no cfg_done; shadows remain as loaded, so no auto-retrigger on same values).
//  NEXT: idx==6 -> DONE; else idx++, retry=0, -> ISSUE.
//  DONE: cfg_done=1 for exactly this cycle -> IDLE.
//  Input change or cfg_start while busy (not HOLD/SETTLE): set pending; serviced once from IDLE.
//  cfg_start also clears cfg_error the cycle it is sampled. cfg_start during SETTLE/HOLD is ignored (pass follows anyway).
//  Latency: cfg_start in IDLE -> i2c_req high 2 cycles later (LOAD, ISSUE).
//  Counters sized to parameters; no wrap: timeout counter saturates, idx max 6.
// TESTING
//  Reset release, i2c_ack 3 cycles after each req, err=0 -> after SETTLE_CYCLES, 7 writes in order
//   0x01..0x09 with reset-time input data, dev=8'hBA, then single cfg_done pulse; cfg_busy falls same cycle as IDLE.
//  In IDLE change exposure to 16'h0400 -> LOAD, full 7-write pass; last write reg 0x09 data 16'h0400.
//  Change row_size to 16'h01df mid-pass (during idx 2 WAIT) -> current pass uses old value; second pass follows with 16'h01df.
//  i2c_err=1 on first 2 attempts of reg 0x03 -> 3 req pulses for 0x03, pass completes, cfg_done=1, cfg_error=0;
//   err on all 4 attempts -> cfg_error=1, no cfg_done, no writes to 0x04+; cfg_start clears error and re-runs.
//  No ack (ACK_TIMEOUT=16 in bench) -> each attempt ends after 16 cycles, 4 attempts, cfg_error=1.
//  Drop cam_soft_reset_n during WAIT of idx 4 -> i2c_req low next cycle, busy held; raise -> SETTLE then full pass from 0x01.

Source files
------------

// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: pushes the seven sensor geometry/exposure registers
// to the image sensor through a req/ack register-write master. A pass runs after
// power-up/soft-reset settle, on any register change, or on cfg_start.
module camera_config_sequencer #(
  parameter logic [7:0] DEV_ADDR      = 8'hBA,
  parameter int         SETTLE_CYCLES = 50000,
  parameter int         ACK_TIMEOUT   = 65535,
  parameter int         RETRY_MAX     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_soft_reset_n,
  input  logic [15:0] start_row,
  input  logic [15:0] start_column,
  input  logic [15:0] row_size,
  input  logic [15:0] column_size,
  input  logic [15:0] row_mode,
  input  logic [15:0] column_mode,
  input  logic [15:0] exposure,
  input  logic        cfg_start,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev,
  output logic [7:0]  i2c_reg,
  output logic [15:0] i2c_data,
  input  logic        i2c_ack,
  input  logic        i2c_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  localparam int NUM_REGS = 7;
  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {HOLD, SETTLE, IDLE, LOAD, ISSUE, WAIT, NEXT, DONE} state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_req_t;

  state_t                         state;
  logic [SW-1:0]                  settle_cnt;
  logic [TW-1:0]                  tmo_cnt;
  logic [RW-1:0]                  retry;
  logic [2:0]                     idx;
  logic                           pending;
  logic [NUM_REGS-1:0][15:0]      cfg_in;
  logic [NUM_REGS-1:0][15:0]      shadow;
  wr_req_t                        sel;
  logic                           changed;
  logic                           timeout;
  logic                           active;

  // Index 0 is start_row, matching write order.
  assign cfg_in  = {exposure, column_mode, row_mode, column_size, row_size, start_column, start_row};
  assign changed = (cfg_in != shadow);
  assign timeout = (tmo_cnt >= TW'(ACK_TIMEOUT - 1));
  assign active  = (state == LOAD) || (state == ISSUE) || (state == WAIT) ||
                   (state == NEXT) || (state == DONE);
  assign i2c_dev  = DEV_ADDR;
  assign cfg_busy = (state != IDLE);

  // Register address / shadow data for the current table entry.
  always_comb begin
    sel = '{addr: 8'h09, data: shadow[6]};
    case (idx)
      3'd0:    sel = '{addr: 8'h01, data: shadow[0]};
      3'd1:    sel = '{addr: 8'h02, data: shadow[1]};
      3'd2:    sel = '{addr: 8'h03, data: shadow[2]};
      3'd3:    sel = '{addr: 8'h04, data: shadow[3]};
      3'd4:    sel = '{addr: 8'h22, data: shadow[4]};
      3'd5:    sel = '{addr: 8'h23, data: shadow[5]};
      default: sel = '{addr: 8'h09, data: shadow[6]};
    endcase
  end

  // Sequencer FSM with registered outputs; soft reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      settle_cnt <= SW'(SETTLE_CYCLES);
      tmo_cnt    <= '0;
      retry      <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      shadow     <= '0;
      i2c_req    <= 1'b0;
      i2c_reg    <= '0;
      i2c_data   <= '0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
    end else if (!cam_soft_reset_n) begin
      // Abandon any in-flight write; a mandatory pass follows release anyway.
      state      <= HOLD;
      settle_cnt <= SW'(SETTLE_CYCLES);
      i2c_req    <= 1'b0;
      cfg_done   <= 1'b0;
      pending    <= 1'b0;
      if (cfg_start) cfg_error <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_start) cfg_error <= 1'b0;
      if (active && (cfg_start || changed)) pending <= 1'b1;
      case (state)
        HOLD: begin
          settle_cnt <= SW'(SETTLE_CYCLES);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= LOAD;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        IDLE: begin
          if (cfg_start || pending || changed) state <= LOAD;
        end
        LOAD: begin
          shadow  <= cfg_in;
          idx     <= '0;
          retry   <= '0;
          pending <= 1'b0;
          state   <= ISSUE;
        end
        ISSUE: begin
          i2c_reg  <= sel.addr;
          i2c_data <= sel.data;
          i2c_req  <= 1'b1;
          tmo_cnt  <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (i2c_ack && !i2c_err) begin
            i2c_req <= 1'b0;
            state   <= NEXT;
          end else if (i2c_ack || timeout) begin
            i2c_req <= 1'b0;
            if (retry < RW'(RETRY_MAX)) begin
              retry <= retry + 1'b1;
              state <= ISSUE;
            end else begin
              cfg_error <= 1'b1;
              state     <= IDLE;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == 3'd6) begin
            cfg_done <= 1'b1;
            state    <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            retry <= '0;
            state <= ISSUE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Directed bench for camera_config_sequencer with a 3-cycle-ack register master model.
module tb_camera_config_sequencer;

  localparam logic [15:0] SR = 16'h0010, SC = 16'h0020, CS = 16'h0280,
                          RM = 16'h0011, CM = 16'h0022;

  logic        clk, reset, cam_soft_reset_n, cfg_start;
  logic [15:0] start_row, start_column, row_size, column_size, row_mode, column_mode, exposure;
  logic        i2c_req, i2c_ack, i2c_err, cfg_busy, cfg_done, cfg_error;
  logic [7:0]  i2c_dev, i2c_reg;
  logic [15:0] i2c_data;

  camera_config_sequencer #(
    .DEV_ADDR(8'hBA), .SETTLE_CYCLES(8), .ACK_TIMEOUT(16), .RETRY_MAX(3)
  ) dut (
    .clk(clk), .reset(reset), .cam_soft_reset_n(cam_soft_reset_n),
    .start_row(start_row), .start_column(start_column), .row_size(row_size),
    .column_size(column_size), .row_mode(row_mode), .column_mode(column_mode),
    .exposure(exposure), .cfg_start(cfg_start),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
    .i2c_ack(i2c_ack), .i2c_err(i2c_err),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [23:0] wq[$];
  int          hq[$];
  int          done_cnt = 0, stable_bad = 0, dev_bad = 0;
  int          rsp_cnt = 0, hlen = 0, err_att = 0, err_n = 0;
  logic        no_ack = 1'b0;
  logic [7:0]  err_reg = 8'h00;
  logic        req_q = 1'b0;
  logic [7:0]  reg_q = 8'h00;
  logic [15:0] data_q = 16'h0000;

  // Master model + write monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    i2c_ack = 1'b0;
    i2c_err = 1'b0;
    if (i2c_req === 1'b1) begin
      if (!req_q) begin
        wq.push_back({i2c_reg, i2c_data});
        if (i2c_dev !== 8'hBA) dev_bad++;
        hlen = 0;
      end else if (i2c_reg !== reg_q || i2c_data !== data_q) begin
        stable_bad++;
      end
      hlen++;
      rsp_cnt++;
      if (!no_ack && rsp_cnt == 3) begin
        i2c_ack = 1'b1;
        if (i2c_reg == err_reg) begin
          if (err_att < err_n) i2c_err = 1'b1;
          err_att++;
        end
      end
    end else begin
      rsp_cnt = 0;
      if (req_q) hq.push_back(hlen);
    end
    if (cfg_done === 1'b1) done_cnt++;
    req_q  = (i2c_req === 1'b1);
    reg_q  = i2c_reg;
    data_q = i2c_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (cfg_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk(tag, {31'd0, cfg_done}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (cfg_busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    chk(tag, {31'd0, cfg_busy}, 32'd0);
  endtask

  task automatic wait_req_reg(input string tag, input logic [7:0] r, input int budget);
    int n = 0;
    while (!(i2c_req === 1'b1 && i2c_reg === r) && n < budget) begin @(negedge clk); n++; end
    chk(tag, {24'd0, i2c_reg}, {24'd0, r});
  endtask

  // One full pass in the queue starting at base, with given row_size/exposure.
  task automatic chk_pass(input string tag, input int base, input logic [15:0] rs, input logic [15:0] ex);
    logic [23:0] e [7];
    e[0] = {8'h01, SR}; e[1] = {8'h02, SC}; e[2] = {8'h03, rs}; e[3] = {8'h04, CS};
    e[4] = {8'h22, RM}; e[5] = {8'h23, CM}; e[6] = {8'h09, ex};
    for (int i = 0; i < 7; i++) chk($sformatf("%s_w%0d", tag, i), {8'd0, wq[base+i]}, {8'd0, e[i]});
  endtask

  initial begin
    int n;
    reset = 1'b1; cam_soft_reset_n = 1'b1; cfg_start = 1'b0;
    start_row = SR; start_column = SC; row_size = 16'h01e0; column_size = CS;
    row_mode = RM; column_mode = CM; exposure = 16'h0100;
    tick(3);
    chk("rst_req", {31'd0, i2c_req}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_err", {31'd0, cfg_error}, 32'd0);
    chk("rst_dev", {24'd0, i2c_dev}, 32'hBA);
    chk("rst_busy", {31'd0, cfg_busy}, 32'd1);

    // Power-up pass: settle 8..0, LOAD, ISSUE, then req.
    reset = 1'b0;
    n = 0;
    while (i2c_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("settle_lat", n, 32'd11);
    wait_done("pwr_done", 300);
    chk("pwr_busy_in_done", {31'd0, cfg_busy}, 32'd1);
    tick(1);
    chk("pwr_busy_idle", {31'd0, cfg_busy}, 32'd0);
    chk("pwr_done_pulse", {31'd0, cfg_done}, 32'd0);
    tick(3);
    chk("pwr_nwr", wq.size(), 32'd7);
    chk_pass("pwr", 0, 16'h01e0, 16'h0100);
    chk("pwr_done_cnt", done_cnt, 32'd1);

    // Exposure change in IDLE triggers a pass.
    wq.delete(); done_cnt = 0;
    exposure = 16'h0400;
    wait_done("exp_done", 300);
    tick(3);
    chk("exp_nwr", wq.size(), 32'd7);
    chk_pass("exp", 0, 16'h01e0, 16'h0400);

    // cfg_start latency: LOAD, ISSUE, then req.
    wq.delete(); done_cnt = 0;
    pulse_start();
    n = 1;
    while (i2c_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("start_lat", n, 32'd3);
    wait_done("start_done", 300);
    tick(3);
    chk("start_nwr", wq.size(), 32'd7);
    chk("start_done_cnt", done_cnt, 32'd1);

    // Mid-pass row_size change: current pass keeps old value, second pass picks it up.
    wq.delete(); done_cnt = 0;
    pulse_start();
    wait_req_reg("mid_wait03", 8'h03, 200);
    row_size = 16'h01df;
    wait_done("mid_done1", 300);
    tick(1);
    wait_done("mid_done2", 300);
    tick(10);
    chk("mid_nwr", wq.size(), 32'd14);
    chk_pass("mid_p1", 0, 16'h01e0, 16'h0400);
    chk_pass("mid_p2", 7, 16'h01df, 16'h0400);
    chk("mid_done_cnt", done_cnt, 32'd2);

    // Two NACKs on reg 0x03, third attempt succeeds.
    wq.delete(); done_cnt = 0; err_reg = 8'h03; err_n = 2; err_att = 0;
    pulse_start();
    wait_done("retry_done", 400);
    tick(3);
    chk("retry_nwr", wq.size(), 32'd9);
    chk("retry_w2", {24'd0, wq[2][23:16]}, 32'h03);
    chk("retry_w3", {24'd0, wq[3][23:16]}, 32'h03);
    chk("retry_w4", {24'd0, wq[4][23:16]}, 32'h03);
    chk("retry_w5", {24'd0, wq[5][23:16]}, 32'h04);
    chk("retry_done_cnt", done_cnt, 32'd1);
    chk("retry_err", {31'd0, cfg_error}, 32'd0);

    // All four attempts NACKed: error, no done, nothing after 0x03.
    wq.delete(); done_cnt = 0; err_n = 4; err_att = 0;
    pulse_start();
    wait_idle("exh_idle", 400);
    tick(3);
    chk("exh_nwr", wq.size(), 32'd6);
    chk("exh_w5", {24'd0, wq[5][23:16]}, 32'h03);
    chk("exh_err", {31'd0, cfg_error}, 32'd1);
    chk("exh_done_cnt", done_cnt, 32'd0);
    chk("exh_busy", {31'd0, cfg_busy}, 32'd0);

    // cfg_start clears error and re-runs.
    wq.delete(); done_cnt = 0; err_reg = 8'h00; err_n = 0; err_att = 0;
    pulse_start();
    chk("clr_err", {31'd0, cfg_error}, 32'd0);
    wait_done("clr_done", 300);
    tick(3);
    chk("clr_nwr", wq.size(), 32'd7);
    chk("clr_done_cnt", done_cnt, 32'd1);

    // No ack at all: four 16-cycle attempts on 0x01, then error.
    wq.delete(); hq.delete(); done_cnt = 0; no_ack = 1'b1;
    pulse_start();
    wait_idle("tmo_idle", 400);
    tick(2);
    chk("tmo_nattempt", hq.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("tmo_len%0d", i), hq[i], 32'd16);
    chk("tmo_nwr", wq.size(), 32'd4);
    chk("tmo_reg", {24'd0, wq[3][23:16]}, 32'h01);
    chk("tmo_err", {31'd0, cfg_error}, 32'd1);
    chk("tmo_done_cnt", done_cnt, 32'd0);

    // Soft reset during idx 4 WAIT: abort, hold, then settle and full pass.
    no_ack = 1'b0;
    pulse_start();
    wait_req_reg("sr_wait22", 8'h22, 300);
    cam_soft_reset_n = 1'b0;
    tick(1);
    chk("sr_req_low", {31'd0, i2c_req}, 32'd0);
    chk("sr_busy", {31'd0, cfg_busy}, 32'd1);
    tick(5);
    chk("sr_busy_hold", {31'd0, cfg_busy}, 32'd1);
    chk("sr_req_hold", {31'd0, i2c_req}, 32'd0);
    wq.delete(); done_cnt = 0;
    cam_soft_reset_n = 1'b1;
    wait_done("sr_done", 300);
    tick(3);
    chk("sr_nwr", wq.size(), 32'd7);
    chk_pass("sr", 0, 16'h01df, 16'h0400);
    chk("sr_done_cnt", done_cnt, 32'd1);
    chk("sr_err", {31'd0, cfg_error}, 32'd0);

    chk("stable", stable_bad, 32'd0);
    chk("dev", dev_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
